// File: rtl/terminal_pkg.sv
// rtl/terminal_pkg.sv - shared constants and FSM state type for the text terminal sequencer
// Contents: screen geometry defaults, control-code bytes, RGB444 colours, sequencer state enum.
package terminal_pkg;

  localparam int TEXT_COLS_DEF = 106;
  localparam int TEXT_ROWS_DEF = 30;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] COL_W    = 8'h11;
  localparam logic [7:0] COL_R    = 8'h12;
  localparam logic [7:0] COL_G    = 8'h13;
  localparam logic [7:0] COL_B    = 8'h14;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  localparam logic [11:0] COLOR_WHITE = 12'hFFF;
  localparam logic [11:0] COLOR_RED   = 12'hF00;
  localparam logic [11:0] COLOR_GREEN = 12'h0F0;
  localparam logic [11:0] COLOR_BLUE  = 12'h00F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_CLR_ISSUE,
    ST_CLR_WAIT
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO with read-ahead head
// Ports: clk/rst (sync, active-high); wdata/push write side; pop read side;
//        head = oldest byte (valid while !empty); full, empty, level = occupancy.
module byte_fifo
  import terminal_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wdata,
  input  logic                     push,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/text_terminal_sequencer.sv
// rtl/text_terminal_sequencer.sv - turns received UART bytes into character-cell write requests
// Ports: clk/rst (sync, active-high); rx_data/rx_valid byte input; char_busy/char_done from
//        the VRAM writer; write_char + ascii_out/color_out/text_x/text_y request;
//        rx_overflow drop pulse; busy; fifo_level occupancy.
module text_terminal_sequencer
  import terminal_pkg::*;
#(
  parameter int          TEXT_COLS     = TEXT_COLS_DEF,
  parameter int          TEXT_ROWS     = TEXT_ROWS_DEF,
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [11:0] DEFAULT_COLOR = 12'hFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          char_busy,
  input  logic                          char_done,
  output logic                          write_char,
  output logic [6:0]                    ascii_out,
  output logic [11:0]                   color_out,
  output logic [6:0]                    text_x,
  output logic [4:0]                    text_y,
  output logic                          rx_overflow,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [6:0] LAST_X = 7'(TEXT_COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(TEXT_ROWS - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] cur_byte;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       no_adv;
  logic       printable;
  logic       last_cell;
  logic [4:0] next_row;
  logic [6:0] adv_x;
  logic [4:0] adv_y;

  assign pop = (state == ST_IDLE) && !fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wdata (rx_data),
    .push  (rx_valid),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign printable = (cur_byte >= CH_SPACE) && (cur_byte <= CH_TILDE);
  assign last_cell = (text_x == LAST_X) && (text_y == LAST_Y);
  assign next_row  = (text_y == LAST_Y) ? '0 : text_y + 5'd1;

  // Row-major cursor step; the last cell wraps to (0,0), which also ends a clear there.
  always_comb begin
    adv_x = text_x + 7'd1;
    adv_y = text_y;
    if (text_x == LAST_X) begin
      adv_x = '0;
      adv_y = next_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) next_state = ST_DECODE;
      end
      ST_DECODE: begin
        if (printable)                                 next_state = ST_ISSUE;
        else if (cur_byte == CH_BS && text_x != '0)    next_state = ST_ISSUE;
        else if (cur_byte == CH_FF)                    next_state = ST_CLR_ISSUE;
        else                                           next_state = ST_IDLE;
      end
      ST_ISSUE: begin
        if (!char_busy) next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (char_done) next_state = ST_IDLE;
      end
      ST_CLR_ISSUE: begin
        if (!char_busy) next_state = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        if (char_done) next_state = last_cell ? ST_IDLE : ST_CLR_ISSUE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    write_char = 1'b0;
    if ((state == ST_ISSUE || state == ST_CLR_ISSUE) && !char_busy) begin
      write_char = 1'b1;
    end
    busy = (state != ST_IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_byte    <= '0;
      ascii_out   <= '0;
      color_out   <= DEFAULT_COLOR;
      text_x      <= '0;
      text_y      <= '0;
      no_adv      <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      rx_overflow <= rx_valid && fifo_full && !pop;
      if (pop) begin
        cur_byte <= fifo_head;
      end
      case (state)
        ST_DECODE: begin
          if (printable) begin
            ascii_out <= cur_byte[6:0];
          end else begin
            case (cur_byte)
              CH_CR: text_x <= '0;
              CH_LF: text_y <= next_row;
              CH_BS: begin
                // Erase the previous cell in place; the write must not move the cursor.
                if (text_x != '0) begin
                  text_x    <= text_x - 7'd1;
                  ascii_out <= CH_SPACE[6:0];
                  no_adv    <= 1'b1;
                end
              end
              CH_FF: begin
                text_x    <= '0;
                text_y    <= '0;
                ascii_out <= CH_SPACE[6:0];
              end
              COL_W:   color_out <= COLOR_WHITE;
              COL_R:   color_out <= COLOR_RED;
              COL_G:   color_out <= COLOR_GREEN;
              COL_B:   color_out <= COLOR_BLUE;
              default: ;
            endcase
          end
        end
        ST_WAIT: begin
          if (char_done) begin
            if (no_adv) begin
              no_adv <= 1'b0;
            end else begin
              text_x <= adv_x;
              text_y <= adv_y;
            end
          end
        end
        ST_CLR_WAIT: begin
          if (char_done) begin
            text_x <= adv_x;
            text_y <= adv_y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_terminal_sequencer.sv
// tb/tb_text_terminal_sequencer.sv - self-checking bench for text_terminal_sequencer
module tb_text_terminal_sequencer;

  localparam int COLS = 106;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        char_busy = 1'b0;
  logic        char_done = 1'b0;
  logic        write_char;
  logic [6:0]  ascii_out;
  logic [11:0] color_out;
  logic [6:0]  text_x;
  logic [4:0]  text_y;
  logic        rx_overflow;
  logic        busy;
  logic [4:0]  fifo_level;

  text_terminal_sequencer #(
    .TEXT_COLS     (COLS),
    .TEXT_ROWS     (ROWS),
    .FIFO_DEPTH    (16),
    .DEFAULT_COLOR (12'hFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .char_busy   (char_busy),
    .char_done   (char_done),
    .write_char  (write_char),
    .ascii_out   (ascii_out),
    .color_out   (color_out),
    .text_x      (text_x),
    .text_y      (text_y),
    .rx_overflow (rx_overflow),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int a;
    int c;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         cur_exp;
  int          n_pass = 0;
  int          n_checks = 0;
  int          mx, my, mcol;
  int          cyc = 0;
  int          writes_seen = 0;
  int          ovf_count = 0;
  int          strobe_cyc = 0;
  int          first_write_cyc = -1;
  bit          prev_wc = 1'b0;
  bit          in_flight = 1'b0;
  logic [30:0] last_wr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [30:0] pk(input int x, input int y, input int a, input int c);
    return {7'(x), 5'(y), 7'(a), 12'(c)};
  endfunction

  // Terminal model: cursor, colour and the ordered list of cells that must be written.
  task automatic model_reset();
    exp_q.delete();
    mx = 0;
    my = 0;
    mcol = 'hFFF;
  endtask

  task automatic model_step();
    if (mx == COLS - 1) begin
      mx = 0;
      my = (my + 1) % ROWS;
    end else begin
      mx++;
    end
  endtask

  task automatic model_byte(input int b);
    if (b >= 'h20 && b <= 'h7E) begin
      exp_q.push_back('{mx, my, b, mcol});
      model_step();
    end else begin
      case (b)
        'h0D: mx = 0;
        'h0A: my = (my + 1) % ROWS;
        'h08: if (mx > 0) begin
          mx--;
          exp_q.push_back('{mx, my, 'h20, mcol});
        end
        'h0C: begin
          for (int yy = 0; yy < ROWS; yy++)
            for (int xx = 0; xx < COLS; xx++)
              exp_q.push_back('{xx, yy, 'h20, mcol});
          mx = 0;
          my = 0;
        end
        'h11: mcol = 'hFFF;
        'h12: mcol = 'hF00;
        'h13: mcol = 'h0F0;
        'h14: mcol = 'h00F;
        default: ;
      endcase
    end
  endtask

  // VRAM writer stand-in: char_done two cycles after each request.
  initial forever begin
    @(negedge clk);
    if (write_char && !rst) begin
      @(posedge clk);
      @(posedge clk);
      #1 char_done = 1'b1;
      @(posedge clk);
      #1 char_done = 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      prev_wc   = 1'b0;
      in_flight = 1'b0;
    end else begin
      if (rx_overflow) ovf_count++;
      if (in_flight) begin
        check("stable_outputs", {text_x, text_y, ascii_out, color_out},
              pk(cur_exp.x, cur_exp.y, cur_exp.a, cur_exp.c));
        if (char_done) in_flight = 1'b0;
      end
      if (write_char) begin
        check("no_back_to_back", prev_wc, 0);
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur_exp = exp_q.pop_front();
          check("write_cell", {text_x, text_y, ascii_out, color_out},
                pk(cur_exp.x, cur_exp.y, cur_exp.a, cur_exp.c));
          in_flight = 1'b1;
        end
        if (first_write_cyc < 0) first_write_cyc = cyc;
        last_wr = {text_x, text_y, ascii_out, color_out};
        writes_seen++;
      end
      if (!busy && !rx_valid) begin
        check("idle_cursor_color", {text_x, text_y, color_out}, {7'(mx), 5'(my), 12'(mcol)});
        check("idle_no_pending", exp_q.size(), 0);
      end
      prev_wc = write_char;
    end
  end

  task automatic send(input int b);
    model_byte(b);
    rx_data    = 8'(b);
    rx_valid   = 1'b1;
    strobe_cyc = cyc;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_drop(input int b);
    rx_data  = 8'(b);
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic send_wait(input int b);
    send(b);
    wait_idle(200);
  endtask

  initial begin
    int s0, ws0, ov0, n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_write_char", write_char, 0);
    check("rst_ascii", ascii_out, 0);
    check("rst_color", color_out, 'hFFF);
    check("rst_x", text_x, 0);
    check("rst_y", text_y, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", rx_overflow, 0);
    check("rst_level", fifo_level, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Printable byte and its latency.
    send('h41);
    s0 = strobe_cyc;
    wait_idle(100);
    check("a_latency", first_write_cyc - s0, 3);
    check("a_write", last_wr, pk(0, 0, 'h41, 'hFFF));
    check("a_cursor_x", text_x, 1);

    // Drive cursor to the last cell, then write there and wrap.
    send_wait('h0D);
    for (int i = 0; i < ROWS - 1; i++) send_wait('h0A);
    for (int i = 0; i < COLS - 1; i++) send_wait('h61 + (i % 26));
    check("pre_wrap_cursor", {text_x, text_y}, {7'd105, 5'd29});
    send_wait('h5A);
    check("wrap_write", last_wr, pk(105, 29, 'h5A, 'hFFF));
    check("wrap_cursor", {text_x, text_y}, {7'd0, 5'd0});

    // CR / LF / BS and colour codes.
    send_wait('h41);
    send_wait('h42);
    send_wait('h08);
    check("bs_write", last_wr, pk(1, 0, 'h20, 'hFFF));
    check("bs_cursor_x", text_x, 1);
    ws0 = writes_seen;
    send_wait('h0D);
    check("cr_x", text_x, 0);
    send_wait('h0A);
    check("lf_y", text_y, 1);
    send_wait('h08);
    check("cr_lf_bs0_no_write", writes_seen - ws0, 0);
    send_wait('h12);
    send_wait('h43);
    check("red_write", last_wr, pk(0, 1, 'h43, 'hF00));
    send_wait('h14);
    send_wait('h00);
    send_wait('h7F);
    send_wait('h44);
    check("blue_write", last_wr, pk(1, 1, 'h44, 'h00F));
    send_wait('h11);
    check("white_color", color_out, 'hFFF);

    // Form feed with bytes queued behind the clear.
    ws0 = writes_seen;
    send('h0C);
    send('h68); send('h65); send('h6C); send('h6C); send('h6F);
    wait_idle(20000);
    check("ff_write_count", writes_seen - ws0, 3185);
    check("ff_then_text_cursor", {text_x, text_y}, {7'd5, 5'd0});

    // Overflow while the writer is busy.
    ws0 = writes_seen;
    ov0 = ovf_count;
    char_busy = 1'b1;
    for (int i = 0; i < 17; i++) send('h30 + i);
    send_drop('h7A);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("ovf_level", fifo_level, 16);
    check("ovf_pulses", ovf_count - ov0, 1);
    check("ovf_no_writes", writes_seen - ws0, 0);
    char_busy = 1'b0;
    wait_idle(500);
    check("ovf_drain_writes", writes_seen - ws0, 17);
    check("ovf_level_empty", fifo_level, 0);

    // Reset in the middle of a clear.
    send_wait('h13);
    ws0 = writes_seen;
    send('h0C);
    n = 0;
    while (writes_seen < ws0 + 500 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("clear_reached_500", writes_seen >= ws0 + 500, 1);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("mid_rst_write_char", write_char, 0);
    check("mid_rst_ascii", ascii_out, 0);
    check("mid_rst_color", color_out, 'hFFF);
    check("mid_rst_cursor", {text_x, text_y}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", fifo_level, 0);
    rst = 1'b0;
    send_wait('h41);
    check("post_rst_write", last_wr, pk(0, 0, 'h41, 'hFFF));
    check("post_rst_cursor_x", text_x, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/text_terminal_sequencer.md
# text_terminal_sequencer

Sequences UART receive bytes into character-cell writes for the text-to-VRAM controller. Buffers incoming bytes, interprets control codes, owns the text cursor, and issues one `write_char` request per printable cell. It also runs a full-screen clear on form-feed. It sits between the UART receiver (100 MHz domain) and the text-to-VRAM controller, replacing ad-hoc cursor logic at top level.

## Interface
Parameters:
- `TEXT_COLS`, 106: cells per row.
- `TEXT_ROWS`, 30: rows per screen.
- `FIFO_DEPTH`, 16: receive byte buffer depth (power of two).
- `DEFAULT_COLOR`, 12'hFFF: colour after reset (RGB444).

Ports:
- `clk`, in, 1: system clock (100 MHz).
- `rst`, in, 1: reset, synchronous, active-high.
- `rx_data`, in, 8: received byte, valid with `rx_valid`.
- `rx_valid`, in, 1: one-cycle strobe per received byte.
- `char_busy`, in, 1: text-to-VRAM controller busy.
- `char_done`, in, 1: one-cycle pulse when the current cell write completes.
- `write_char`, out, 1: one-cycle request to write one cell.
- `ascii_out`, out, 7: character code for the request.
- `color_out`, out, 12: foreground colour for the request.
- `text_x`, out, 7: target column (0..TEXT_COLS-1).
- `text_y`, out, 5: target row (0..TEXT_ROWS-1).
- `rx_overflow`, out, 1: one-cycle pulse when a byte is dropped because the FIFO is full.
- `busy`, out, 1: high whenever the FSM is not in IDLE or the FIFO is non-empty.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO:** push on `rx_valid`. Pop only in IDLE. If the FIFO is full and a pop happens in the same cycle, the push is accepted. If the FIFO is full with no pop, the byte is dropped and `rx_overflow` pulses.
- **FSM states:** IDLE, DECODE, ISSUE, WAIT, CLR_ISSUE, CLR_WAIT.
- **IDLE:** if the FIFO is non-empty, pop the head into `cur_byte` and go to DECODE.
- **DECODE:** acts on `cur_byte`, then moves to the state given below.
  - 0x20–0x7E (printable): `ascii_out` = byte[6:0], go to ISSUE.
  - 0x0D (CR): `text_x` = 0, go to IDLE.
  - 0x0A (LF): `text_y` = `text_y`+1, or 0 if it was TEXT_ROWS-1. Go to IDLE.
  - 0x08 (BS):
    - If `text_x` > 0: `text_x` -= 1, `ascii_out` = 0x20, set `no_adv`, go to ISSUE.
    - If `text_x` == 0: no-op, go to IDLE.
  - 0x0C (FF): `text_x` = `text_y` = 0, `ascii_out` = 0x20, go to CLR_ISSUE.
  - 0x11 / 0x12 / 0x13 / 0x14: set `color_out` to FFF / F00 / 0F0 / 00F, go to IDLE.
  - Any other byte: discarded, go to IDLE.
- **ISSUE:** wait while `char_busy` is high. Otherwise pulse `write_char` and go to WAIT.
- **WAIT:** on `char_done`:
  - If `no_adv` is set: clear it, cursor unchanged.
  - Otherwise advance the cursor: x+1. At TEXT_COLS-1, x=0 and y+1. At row TEXT_ROWS-1, y wraps to 0.
  - Go to IDLE.
- **CLR_ISSUE / CLR_WAIT:** same handshake as ISSUE/WAIT, stepping row-major through all TEXT_COLS×TEXT_ROWS cells with 0x20. After the done of the last cell (105, 29), set the cursor to (0,0) and go to IDLE.
- Bytes arriving during a clear or a write are buffered in the FIFO.
- `char_done` outside WAIT/CLR_WAIT is ignored.

## Timing
- **Reset values:**
  - `write_char`=0, `ascii_out`=0, `color_out`=DEFAULT_COLOR.
  - `text_x`=0, `text_y`=0, `busy`=0, `rx_overflow`=0, `fifo_level`=0.
  - FIFO emptied, FSM in IDLE.
- **Latency:** with an empty FIFO, idle FSM and `char_busy`=0, a printable byte strobed in cycle N produces `write_char`=1 in cycle N+3 (N+1 pop, N+2 decode, N+3 issue).
- **Control-code latency:** a control code takes effect on the cursor/colour outputs in cycle N+3.
- **Output stability:** `ascii_out`, `color_out`, `text_x`, `text_y` are stable from the ISSUE cycle through the `char_done` cycle.
- **Cursor update:** the cursor advance is visible in the cycle after `char_done`.
- **Request rate:** at most one outstanding request. `write_char` is never asserted in two consecutive cycles.
- **Reset during an operation:** `rst` in any state aborts it. `write_char` is 0 from the next cycle. A partially complete clear is abandoned.
- **Full clear duration:** 3180 handshakes.

## Structure
- Package `terminal_pkg` holds:
  - TEXT_COLS/TEXT_ROWS defaults.
  - Control-code constants (CR, LF, BS, FF, COL_W/R/G/B).
  - Colour constants.
  - FSM state enum.
- Sub-module `byte_fifo`: synchronous FIFO with push/pop/full/empty/level, read-ahead head. Provides the buffer; all other logic lives in `text_terminal_sequencer`.

## Test plan
- **Printable byte:** send 'A' (0x41) after reset with `char_done` 2 cycles after `write_char`. Expect `write_char` at N+3 with ascii=0x41, x=0, y=0, color=FFF. Then x=1.
- **Line wrap:** set cursor to x=105, y=29 via bytes and send 'Z'. Expect a write at (105,29), then cursor (0,0).
- **CR/LF/BS:** send "AB", 0x08, 0x0D, 0x0A. Expect:
  - BS writes 0x20 at x=1 and leaves x=1.
  - CR sets x=0.
  - LF sets y=1.
  - No `write_char` for CR/LF.
- **Form-feed clear:** send 0x0C followed by 5 bytes. Expect 3180 space writes in row-major order, cursor (0,0), then the 5 buffered bytes processed.
- **Overflow:** hold `char_busy`=1 and strobe 18 bytes. Expect `fifo_level`=16 and 1 `rx_overflow` pulse (the byte popped to DECODE frees 1 slot). Release `char_busy` and expect the remaining bytes in order.
- **Mid-operation reset:** assert `rst` during the clear at cell 500. Expect all outputs at reset values the next cycle. A new 'A' writes at (0,0) with color FFF.
